// File: rtl/link_redundancy_switch_if.sv
// Link redundancy switch bundle: raw link health and force request in,
// selected channel, status and switch pulses out.
interface link_redundancy_switch_if #(
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0] link_ok;
  logic                force_en;
  logic [2:0]          force_idx;
  logic [CHANNELS-1:0] link_enable;
  logic [2:0]          active_idx;
  logic                active_valid;
  logic                pre_switch;
  logic                post_switch;
  logic [15:0]         switch_count;

  modport master (
    output link_ok,
    output force_en,
    output force_idx,
    input  link_enable,
    input  active_idx,
    input  active_valid,
    input  pre_switch,
    input  post_switch,
    input  switch_count
  );

  modport slave (
    input  link_ok,
    input  force_en,
    input  force_idx,
    output link_enable,
    output active_idx,
    output active_valid,
    output pre_switch,
    output post_switch,
    output switch_count
  );
endinterface

// File: rtl/link_redundancy_switch.sv
// N-channel failover controller: qualifies link health and selects one
// downstream channel, with a guard gap bracketed by pre/post pulses.
module link_redundancy_switch #(
  parameter int    CHANNELS      = 2,
  parameter int    STABLE_CYCLES = 1250,
  parameter int    GUARD_CYCLES  = 16,
  parameter string REVERT        = "FALSE",
  parameter int    PRIMARY       = 0
) (
  input logic clk,
  input logic rst_n,
  link_redundancy_switch_if.slave bus
);

  localparam logic [15:0] STABLE = 16'(STABLE_CYCLES);
  localparam logic [7:0]  GUARD  = 8'(GUARD_CYCLES);
  localparam logic [3:0]  NCH    = 4'(CHANNELS);
  localparam logic [2:0]  PRI    = 3'(PRIMARY);
  localparam bit          REV_EN = (REVERT == "TRUE");

  typedef enum logic [1:0] {
    S_NONE,
    S_ACTIVE,
    S_GUARD
  } state_t;

  state_t state, nx_state;

  logic [2:0]  target, nx_target;
  logic [7:0]  gcnt, nx_gcnt;

  logic [CHANNELS-1:0] en_q, nx_en;
  logic [2:0]          idx_q, nx_idx;
  logic                valid_q, nx_valid;
  logic                pre_q, nx_pre;
  logic                post_q, nx_post;
  logic [15:0]         cnt_q, nx_cnt;

  logic [CHANNELS-1:0] good;
  logic [7:0]          good_pad;

  // Qualifier: immediate fail, STABLE_CYCLES consecutive highs to pass
  for (genvar g = 0; g < CHANNELS; g++) begin : g_qual
    logic [15:0] qcnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        qcnt    <= '0;
        good[g] <= 1'b0;
      end else if (!bus.link_ok[g]) begin
        qcnt    <= '0;
        good[g] <= 1'b0;
      end else begin
        if (qcnt != STABLE) qcnt <= qcnt + 16'd1;
        good[g] <= (qcnt == STABLE);
      end
    end
  end

  always_comb begin
    good_pad = '0;
    good_pad[CHANNELS-1:0] = good;
  end

  logic       force_ok, rev_ok, low_ok;
  logic       pref_ok, cand_ok;
  logic [2:0] pref_idx, cand_idx, low_idx;

  always_comb begin
    force_ok = bus.force_en
            && ({1'b0, bus.force_idx} < NCH)
            && good_pad[bus.force_idx];
    rev_ok   = REV_EN && good_pad[PRI];
    low_ok   = 1'b0;
    low_idx  = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (good[i]) begin
        low_ok  = 1'b1;
        low_idx = 3'(i);
      end
    end
    pref_ok  = force_ok | rev_ok;
    pref_idx = force_ok ? bus.force_idx : PRI;
    cand_ok  = pref_ok | low_ok;
    cand_idx = pref_ok ? pref_idx : low_idx;
  end

  logic leave, switch_to, tgt_good, guard_done;
  logic [CHANNELS-1:0] tgt_hot;

  // A lowest-index candidate alone never displaces a good channel
  always_comb begin
    leave      = !good_pad[idx_q] || (pref_ok && pref_idx != idx_q);
    switch_to  = cand_ok && cand_idx != idx_q;
    tgt_good   = good_pad[target];
    guard_done = tgt_good && gcnt == 8'd0;
    for (int i = 0; i < CHANNELS; i++) begin
      tgt_hot[i] = (target == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_NONE;
      target  <= '0;
      gcnt    <= '0;
      en_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      pre_q   <= 1'b0;
      post_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= nx_state;
      target  <= nx_target;
      gcnt    <= nx_gcnt;
      en_q    <= nx_en;
      idx_q   <= nx_idx;
      valid_q <= nx_valid;
      pre_q   <= nx_pre;
      post_q  <= nx_post;
      cnt_q   <= nx_cnt;
    end
  end

  always_comb begin
    nx_state  = state;
    nx_target = target;
    nx_gcnt   = gcnt;
    unique case (state)
      S_NONE: begin
        if (cand_ok) begin
          nx_state  = S_GUARD;
          nx_target = cand_idx;
          nx_gcnt   = GUARD;
        end
      end
      S_ACTIVE: begin
        if (leave) begin
          if (switch_to) begin
            nx_state  = S_GUARD;
            nx_target = cand_idx;
            nx_gcnt   = GUARD;
          end else begin
            nx_state = S_NONE;
          end
        end
      end
      S_GUARD: begin
        if (!tgt_good) begin
          if (cand_ok) begin
            nx_target = cand_idx;
            nx_gcnt   = GUARD;
          end else begin
            nx_state = S_NONE;
          end
        end else if (guard_done) begin
          nx_state = S_ACTIVE;
        end else begin
          nx_gcnt = gcnt - 8'd1;
        end
      end
      default: nx_state = S_NONE;
    endcase
  end

  always_comb begin
    nx_en    = en_q;
    nx_idx   = idx_q;
    nx_valid = valid_q;
    nx_pre   = 1'b0;
    nx_post  = 1'b0;
    nx_cnt   = cnt_q;
    unique case (1'b1)
      (state == S_ACTIVE) && leave: begin
        nx_pre   = 1'b1;
        nx_en    = '0;
        nx_valid = 1'b0;
      end
      (state == S_GUARD) && guard_done: begin
        nx_en    = tgt_hot;
        nx_idx   = target;
        nx_valid = 1'b1;
        nx_post  = 1'b1;
        if (cnt_q != 16'hFFFF) nx_cnt = cnt_q + 16'd1;
      end
      default: ;
    endcase
  end

  assign bus.link_enable  = en_q;
  assign bus.active_idx   = idx_q;
  assign bus.active_valid = valid_q;
  assign bus.pre_switch   = pre_q;
  assign bus.post_switch  = post_q;
  assign bus.switch_count = cnt_q;

endmodule
